multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle RV32I core (lw, sw, R-type, addi-class I-type, beq, jal).
//  Sequences one shared ALU, one unified instruction/data memory and the register file over 3-5 cycles per instruction.
//  Drives all datapath mux selects and write strobes; contains the ALU and immediate decoders.
//  Stalls on a memory ready handshake.
// PARAMETERS
//  USE_MEM_READY    1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready treated as 1
//  HALT_ON_ILLEGAL  1  1: unknown opcode in DECODE -> HALT; 0: -> FETCH (instruction skipped)
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes current access this cycle
//  pcWrite     out  1  PC register enable
//  adrSrc      out  1  mem address: 0=PC, 1=ALUOut
//  memWrite    out  1  data memory write strobe
//  irWrite     out  1  IR/OldPC enable
//  resSrc      out  2  result mux: 00=ALUOut, 01=ReadData, 10=ALUResult
//  aluSrcA     out  2  00=PC, 01=OldPC, 10=rs1 data
//  aluSrcB     out  2  00=rs2 data, 01=ImmExt, 10=constant 4
//  immSrc      out  2  00=I, 01=S, 10=B, 11=J (combinational from op, every state)
//  regWrite    out  1  register file write strobe
//  aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  state       out  4  current state encoding (debug)
//  illegal     out  1  high while in HALT
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7
//    EXECI=8 JAL=9 BEQ=10 HALT=11. Unlisted encodings -> FETCH next cycle.
//  Reset: state=FETCH; while rst_n=0 pcWrite/irWrite/memWrite/regWrite forced 0.
//  Outputs not listed in a state: strobes 0, selects 00, aluOp 00.
//  FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resSrc=10.
//    irWrite=pcWrite=mem_ready; stays in FETCH until mem_ready, then DECODE.
//  DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target into ALUOut).
//    Next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI,
//    1101111->JAL, 1100011->BEQ, other->HALT or FETCH per HALT_ON_ILLEGAL.
//  MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: adrSrc=1; waits for mem_ready, then MEMWB.
//  MEMWB: resSrc=01, regWrite=1 -> FETCH.
//  MEMWRITE: adrSrc=1, memWrite=1 held until mem_ready cycle (inclusive), then FETCH.
//  EXECR: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALUWB.
//  EXECI: aluSrcA=10, aluSrcB=01, aluOp=10 -> ALUWB.
//  ALUWB: resSrc=00, regWrite=1 -> FETCH.
//  JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resSrc=00, pcWrite=1 -> ALUWB (rd=OldPC+4).
//  BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resSrc=00, pcWrite=zero -> FETCH.
//  HALT: all strobes 0, illegal=1; exit only via reset.
//  ALU decode: aluOp 00->add, 01->sub, 10 by funct3:
//    000 -> sub if (op[5]&funct7b5) else add; 010->slt; 110->or; 111->and; other->add.
//    aluOp 11 -> add.
//  Latency (mem_ready=1): lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
//  mem_ready outside those states is ignored.
//  rst_n low mid-instruction: immediate return to FETCH; partial instruction discarded, no strobe glitch.
// TESTING
//  lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0; regWrite=1 with resSrc=01 only in state 4.
//  sw, mem_ready low 2 cycles in MEMWRITE -> memWrite high 3 cycles, adrSrc=1, then FETCH.
//  R-type funct3=000 funct7b5=1 -> EXECR aluControl=001; funct3=111 -> 010; addi funct7b5=1 -> 000.
//  beq zero=1 -> pcWrite=1 in BEQ; zero=0 -> pcWrite=0; both return to FETCH after 3 cycles.
//  jal -> 0,1,9,7,0; pcWrite in FETCH and JAL; immSrc=11; regWrite in ALUWB.
//  op=1111111, HALT_ON_ILLEGAL=1 -> HALT, illegal=1; rst_n pulse low in any state -> FETCH, strobes 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences the shared ALU, unified memory and
// register file, and decodes ALU operation and immediate format.
module multicycle_ctrl #(
   parameter bit USE_MEM_READY   = 1'b1,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] immSrc,
   output logic       regWrite,
   output logic [2:0] aluControl,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StAluWb    = 4'd7,
      StExecI    = 4'd8,
      StJal      = 4'd9,
      StBeq      = 4'd10,
      StHalt     = 4'd11
   } state_e;

   localparam logic [6:0] OpLw  = 7'b0000011;
   localparam logic [6:0] OpSw  = 7'b0100011;
   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpJal = 7'b1101111;
   localparam logic [6:0] OpBeq = 7'b1100011;

   state_e     state_q, state_d;
   logic       rdy;
   logic       fetch_q, jal_q, beq_q, adr_q, memw_q, regw_q, halt_q;
   logic [1:0] res_q, srca_q, srcb_q, aluop_q;

   assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:    state_d = rdy ? StDecode : StFetch;
         StDecode: begin
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpR:        state_d = StExecR;
               OpI:        state_d = StExecI;
               OpJal:      state_d = StJal;
               OpBeq:      state_d = StBeq;
               default:    state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
            endcase
         end
         StMemAdr: begin
            if (op == OpLw)      state_d = StMemRead;
            else if (op == OpSw) state_d = StMemWrite;
            else                 state_d = StFetch;
         end
         StMemRead:  state_d = rdy ? StMemWb : StMemRead;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = rdy ? StFetch : StMemWrite;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StJal:      state_d = StAluWb;
         StBeq:      state_d = StFetch;
         StHalt:     state_d = StHalt;
         default:    state_d = StFetch;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q; only the
   // mem_ready/zero-qualified strobes are finished combinationally below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         fetch_q <= 1'b1;
         jal_q   <= 1'b0;
         beq_q   <= 1'b0;
         adr_q   <= 1'b0;
         memw_q  <= 1'b0;
         regw_q  <= 1'b0;
         halt_q  <= 1'b0;
         res_q   <= 2'b10;
         srca_q  <= 2'b00;
         srcb_q  <= 2'b10;
         aluop_q <= 2'b00;
      end else begin
         state_q <= state_d;
         fetch_q <= 1'b0;
         jal_q   <= 1'b0;
         beq_q   <= 1'b0;
         adr_q   <= 1'b0;
         memw_q  <= 1'b0;
         regw_q  <= 1'b0;
         halt_q  <= 1'b0;
         res_q   <= 2'b00;
         srca_q  <= 2'b00;
         srcb_q  <= 2'b00;
         aluop_q <= 2'b00;
         case (state_d)
            StFetch: begin
               fetch_q <= 1'b1;
               res_q   <= 2'b10;
               srcb_q  <= 2'b10;
            end
            StDecode: begin
               srca_q <= 2'b01;
               srcb_q <= 2'b01;
            end
            StMemAdr: begin
               srca_q <= 2'b10;
               srcb_q <= 2'b01;
            end
            StMemRead: adr_q <= 1'b1;
            StMemWb: begin
               res_q  <= 2'b01;
               regw_q <= 1'b1;
            end
            StMemWrite: begin
               adr_q  <= 1'b1;
               memw_q <= 1'b1;
            end
            StExecR: begin
               srca_q  <= 2'b10;
               aluop_q <= 2'b10;
            end
            StExecI: begin
               srca_q  <= 2'b10;
               srcb_q  <= 2'b01;
               aluop_q <= 2'b10;
            end
            StAluWb: regw_q <= 1'b1;
            StJal: begin
               srca_q <= 2'b01;
               srcb_q <= 2'b10;
               jal_q  <= 1'b1;
            end
            StBeq: begin
               srca_q  <= 2'b10;
               aluop_q <= 2'b01;
               beq_q   <= 1'b1;
            end
            StHalt:  halt_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign pcWrite  = rst_n & ((fetch_q & rdy) | jal_q | (beq_q & zero));
   assign irWrite  = rst_n & fetch_q & rdy;
   assign memWrite = rst_n & memw_q;
   assign regWrite = rst_n & regw_q;
   assign adrSrc   = adr_q;
   assign resSrc   = res_q;
   assign aluSrcA  = srca_q;
   assign aluSrcB  = srcb_q;
   assign state    = state_q;
   assign illegal  = halt_q;

   always_comb begin
      aluControl = 3'b000;
      case (aluop_q)
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   always_comb begin
      immSrc = 2'b00;
      case (op)
         OpSw:    immSrc = 2'b01;
         OpBeq:   immSrc = 2'b10;
         OpJal:   immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized instruction
// stream compared against a per-instruction state-path model.
module tb_multicycle_ctrl;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RTY  = 7'b0110011;
   localparam logic [6:0] ITY  = 7'b0010011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] BAD  = 7'b1111111;
   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] AND_ = 3'b010;
   localparam logic [2:0] OR_  = 3'b011;
   localparam logic [2:0] SLT  = 3'b101;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] a;
      logic [1:0] b;
      logic       regw;
      logic [2:0] alu;
      logic       ill;
   } outs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
   logic [1:0] resSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   int m_path[$];

   multicycle_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcWrite    (pcWrite),
      .adrSrc     (adrSrc),
      .memWrite   (memWrite),
      .irWrite    (irWrite),
      .resSrc     (resSrc),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .immSrc     (immSrc),
      .regWrite   (regWrite),
      .aluControl (aluControl),
      .state      (state),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Reference: the operation each instruction class asks of the ALU in a given phase.
   function automatic logic [2:0] exp_alu(int st, logic [2:0] f3, logic f7);
      if (st == 10) return SUB;
      if (st == 6 || st == 8) begin
         case (f3)
            3'd0:    return (st == 6 && f7) ? SUB : ADD;  // addi never subtracts
            3'd2:    return SLT;
            3'd6:    return OR_;
            3'd7:    return AND_;
            default: return ADD;
         endcase
      end
      return ADD;
   endfunction

   function automatic logic [1:0] exp_imm(logic [6:0] o);
      if (o == SW)  return 2'b01;
      if (o == BEQ) return 2'b10;
      if (o == JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic outs_t model_out(int st, logic mr, logic zr, logic [2:0] f3, logic f7);
      outs_t e;
      e = '0;
      case (st)
         0:  begin e.pcw = mr; e.irw = mr; e.res = 2'b10; e.b = 2'b10; end
         1:  begin e.a = 2'b01; e.b = 2'b01; end
         2:  begin e.a = 2'b10; e.b = 2'b01; end
         3:  e.adr = 1'b1;
         4:  begin e.res = 2'b01; e.regw = 1'b1; end
         5:  begin e.adr = 1'b1; e.memw = 1'b1; end
         6:  e.a = 2'b10;
         7:  e.regw = 1'b1;
         8:  begin e.a = 2'b10; e.b = 2'b01; end
         9:  begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
         10: begin e.a = 2'b10; e.pcw = zr; end
         11: e.ill = 1'b1;
         default: ;
      endcase
      e.alu = exp_alu(st, f3, f7);
      return e;
   endfunction

   task automatic pick_instr();
      int k;
      k = $urandom_range(0, 5);
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      case (k)
         0:       begin op = LW;  m_path = '{0, 1, 2, 3, 4}; end
         1:       begin op = SW;  m_path = '{0, 1, 2, 5}; end
         2:       begin op = RTY; m_path = '{0, 1, 6, 7}; end
         3:       begin op = ITY; m_path = '{0, 1, 8, 7}; end
         4:       begin op = JAL; m_path = '{0, 1, 9, 7}; end
         default: begin op = BEQ; m_path = '{0, 1, 10}; end
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      op = LW; mem_ready = 1'b1; zero = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", state);
      end
      checks++;
      if ({pcWrite, irWrite, memWrite, regWrite, illegal} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {pcWrite, irWrite, memWrite, regWrite, illegal});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({pcWrite, irWrite, adrSrc, aluSrcB, resSrc} !== 7'b1101010) begin
         errors++;
         $display("FAIL fetch_after_reset: got %b expected 1101010",
                  {pcWrite, irWrite, adrSrc, aluSrcB, resSrc});
      end
      @(negedge clk);
   endtask

   task automatic test_lw();
      int exp_st[6] = '{0, 1, 2, 3, 4, 0};
      do_reset();
      op = LW; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (state !== 4'(exp_st[i])) begin
            errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
         end
         checks++;
         if ((regWrite && resSrc == 2'b01) !== (exp_st[i] == 4)) begin
            errors++;
            $display("FAIL lw_writeback[%0d]: got regWrite=%b resSrc=%b expected wb=%0d",
                     i, regWrite, resSrc, exp_st[i] == 4);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_sw_stall();
      logic mr_seq[7] = '{1, 1, 1, 0, 0, 1, 1};
      int   n_wr = 0;
      do_reset();
      op = SW;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr_seq[i];
         #1;
         if (memWrite) begin
            n_wr++;
            checks++;
            if (adrSrc !== 1'b1) begin
               errors++; $display("FAIL sw_adrsrc[%0d]: got %b expected 1", i, adrSrc);
            end
         end
         if (i == 6) begin
            checks++;
            if (state !== 4'd0) begin
               errors++; $display("FAIL sw_return: got state %0d expected 0", state);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n_wr != 3) begin
         errors++; $display("FAIL sw_memwrite_cycles: got %0d expected 3", n_wr);
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_alu_decode();
      logic [6:0] c_op[6]  = '{RTY, RTY, ITY, RTY, RTY, RTY};
      logic [2:0] c_f3[6]  = '{3'd0, 3'd7, 3'd0, 3'd2, 3'd6, 3'd0};
      logic       c_f7[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] c_alu[6] = '{SUB, AND_, ADD, SLT, OR_, ADD};
      int         c_st[6]  = '{6, 6, 8, 6, 6, 6};
      for (int k = 0; k < 6; k++) begin
         bit found = 0;
         do_reset();
         op = c_op[k]; funct3 = c_f3[k]; funct7b5 = c_f7[k]; mem_ready = 1'b1;
         for (int c = 0; c < 6 && !found; c++) begin
            #1;
            if (state == 4'(c_st[k])) begin
               found = 1;
               checks++;
               if (aluControl !== c_alu[k]) begin
                  errors++;
                  $display("FAIL alu_decode[%0d]: got %b expected %b", k, aluControl, c_alu[k]);
               end
            end
            @(negedge clk);
         end
         checks++;
         if (!found) begin
            errors++; $display("FAIL alu_exec_reached[%0d]: got 0 expected 1", k);
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 0; z < 2; z++) begin
         do_reset();
         op = BEQ; mem_ready = 1'b1; zero = 1'(z);
         for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 2) begin
               checks++;
               if (state !== 4'd10 || pcWrite !== 1'(z)) begin
                  errors++;
                  $display("FAIL beq_branch[z=%0d]: got state=%0d pcWrite=%b expected 10/%0d",
                           z, state, pcWrite, z);
               end
            end
            if (i == 3) begin
               checks++;
               if (state !== 4'd0) begin
                  errors++; $display("FAIL beq_return[z=%0d]: got %0d expected 0", z, state);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_jal();
      int exp_st[5] = '{0, 1, 9, 7, 0};
      do_reset();
      op = JAL; mem_ready = 1'b1; zero = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (state !== 4'(exp_st[i]) || immSrc !== 2'b11 ||
             pcWrite !== (exp_st[i] == 0 || exp_st[i] == 9) || regWrite !== (exp_st[i] == 7)) begin
            errors++;
            $display("FAIL jal[%0d]: got st=%0d imm=%b pcw=%b rw=%b expected st=%0d imm=11",
                     i, state, immSrc, pcWrite, regWrite, exp_st[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      int    idx = 0;
      int    est;
      outs_t e, act;
      do_reset();
      pick_instr();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         zero      = 1'($urandom_range(0, 1));
         #1;
         est = m_path[idx];
         e   = model_out(est, mem_ready, zero, funct3, funct7b5);
         act = {pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
                regWrite, aluControl, illegal};
         checks++;
         if (state !== 4'(est)) begin
            errors++; $display("FAIL rnd_state@%0d: got %0d expected %0d", cyc, state, est);
         end
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL rnd_outs@%0d st=%0d: got %b expected %b", cyc, est, act, e);
         end
         checks++;
         if (immSrc !== exp_imm(op)) begin
            errors++;
            $display("FAIL rnd_imm@%0d: got %b expected %b", cyc, immSrc, exp_imm(op));
         end
         if (!((est == 0 || est == 3 || est == 5) && !mem_ready)) begin
            idx++;
            if (idx == m_path.size()) begin
               idx = 0;
               pick_instr();
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      int exp_st[6] = '{0, 1, 11, 11, 11, 11};
      do_reset();
      op = BAD; mem_ready = 1'b1; zero = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (state !== 4'(exp_st[i]) || illegal !== (exp_st[i] == 11) ||
             (exp_st[i] == 11 && {pcWrite, irWrite, memWrite, regWrite} !== 4'b0)) begin
            errors++;
            $display("FAIL illegal[%0d]: got st=%0d ill=%b strobes=%b expected st=%0d",
                     i, state, illegal, {pcWrite, irWrite, memWrite, regWrite}, exp_st[i]);
         end
         @(negedge clk);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL halt_exit: got st=%0d ill=%b expected 0/0", state, illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      op = LW;
   endtask

   task automatic test_reset_mid();
      for (int t = 0; t < 10; t++) begin
         do_reset();
         pick_instr();
         mem_ready = 1'b1; zero = 1'b1;
         repeat ($urandom_range(0, 4)) @(negedge clk);
         #3;
         rst_n = 1'b0;
         #1;
         checks++;
         if (state !== 4'd0 || {pcWrite, irWrite, memWrite, regWrite} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got st=%0d strobes=%b expected 0/0000",
                     t, state, {pcWrite, irWrite, memWrite, regWrite});
         end
         @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      op = LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      test_reset();
      test_lw();
      test_sw_stall();
      test_alu_decode();
      test_beq();
      test_jal();
      test_random();
      test_illegal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
